// File: rtl/write_buffer_pkg.sv
// Shared types for the posted write buffer: upstream/downstream FSM encodings and default depth.
// Optional coalescing of writes is enabled with the WRITE_BUFFER_COALESCE_EN macro.
package write_buffer_pkg;

    localparam int WB_DEFAULT_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_HIT  = 2'd1,
        RD_MISS = 2'd2
    } up_state_e;

    typedef enum logic [1:0] {
        DS_IDLE       = 2'd0,
        DS_ISSUE_WAIT = 2'd1,
        DS_BUSY       = 2'd2
    } ds_state_e;

endpackage

// File: rtl/write_buffer_fifo.sv
// Circular store of posted writes with a parallel newest-match address search.
// With WRITE_BUFFER_COALESCE_EN the search also yields a merge target that skips a head in flight.
module write_buffer_fifo
    import write_buffer_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int WORD_WIDTH = 64,
    parameter int DEPTH      = WB_DEFAULT_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [ADDR_WIDTH-1:0]    addr_i,
    input  logic [WORD_WIDTH-1:0]    data_i,
`ifdef WRITE_BUFFER_COALESCE_EN
    input  logic                     head_busy_i,
    input  logic                     merge_i,
    output logic                     co_hit_o,
    output logic [$clog2(DEPTH)-1:0] co_idx_o,
`endif
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [ADDR_WIDTH-1:0]    head_addr_o,
    output logic [WORD_WIDTH-1:0]    head_data_o,
    output logic                     hit_o,
    output logic [WORD_WIDTH-1:0]    hit_data_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
    logic [WORD_WIDTH-1:0] data_q [DEPTH];
    logic [PW-1:0]         head_q;
    logic [PW-1:0]         tail_q;
    logic [CW-1:0]         count_q;

    // Entry storage, ring pointers and occupancy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            if (push_i) begin
                addr_q[tail_q] <= addr_i;
                data_q[tail_q] <= data_i;
                tail_q         <= tail_q + PW'(1);
            end
`ifdef WRITE_BUFFER_COALESCE_EN
            if (merge_i) begin
                data_q[co_idx_o] <= data_i;
            end
`endif
            if (pop_i) begin
                head_q <= head_q + PW'(1);
            end
            count_q <= count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    // Scan oldest to newest so the newest matching entry wins
    always_comb begin
        logic [PW-1:0] idx_v;
        logic          match_v;
        idx_v      = '0;
        match_v    = 1'b0;
        hit_o      = 1'b0;
        hit_data_o = '0;
`ifdef WRITE_BUFFER_COALESCE_EN
        co_hit_o   = 1'b0;
        co_idx_o   = '0;
`endif
        for (int k = 0; k < DEPTH; k++) begin
            idx_v      = head_q + PW'(k);
            match_v    = (CW'(k) < count_q) && (addr_q[idx_v] == addr_i);
            hit_o      = hit_o | match_v;
            hit_data_o = match_v ? data_q[idx_v] : hit_data_o;
`ifdef WRITE_BUFFER_COALESCE_EN
            // The head already handed to ram must not be modified underneath it
            match_v    = match_v && ((k != 0) || !head_busy_i);
            co_hit_o   = co_hit_o | match_v;
            co_idx_o   = match_v ? idx_v : co_idx_o;
`endif
        end
    end

    assign count_o     = count_q;
    assign head_addr_o = addr_q[head_q];
    assign head_data_o = data_q[head_q];

endmodule

// File: rtl/write_buffer.sv
// Posted-write buffer between cache and ram: single-cycle write acceptance, background drain,
// read forwarding on hit and read bypass on miss. Coalescing is selected by WRITE_BUFFER_COALESCE_EN.
module write_buffer
    import write_buffer_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int WORD_WIDTH = 64,
    parameter int DEPTH      = WB_DEFAULT_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [WORD_WIDTH-1:0] din,
    output logic [WORD_WIDTH-1:0] dout,
    input  logic                  re,
    input  logic                  we,
    output logic                  ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WORD_WIDTH-1:0] mem_din,
    input  logic [WORD_WIDTH-1:0] mem_dout,
    output logic                  mem_re,
    output logic                  mem_we,
    input  logic                  mem_ready
);

    localparam int CW = $clog2(DEPTH) + 1;

    up_state_e             state_q, state_d;
    ds_state_e             ds_q, ds_d;
    logic                  ready_q, ready_d;
    logic [WORD_WIDTH-1:0] dout_q, dout_d;
    logic                  mem_re_q, mem_re_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [WORD_WIDTH-1:0] mem_din_q, mem_din_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic                  rd_issued_q, rd_issued_d;
    logic                  op_rd_q, op_rd_d;

    logic                  wr_req_s, rd_req_s;
    logic                  issue_rd_s, issue_wr_s, done_s;
    logic                  push_s, pop_s;
    logic [CW-1:0]         count_s, count_nx_s;
    logic [ADDR_WIDTH-1:0] head_addr_s;
    logic [WORD_WIDTH-1:0] head_data_s;
    logic                  hit_s;
    logic [WORD_WIDTH-1:0] hit_data_s;

    assign wr_req_s   = ready_q & we;
    assign rd_req_s   = ready_q & re & ~we;
    assign issue_rd_s = (ds_q == DS_IDLE) && mem_ready && (state_q == RD_MISS) && !rd_issued_q;
    assign issue_wr_s = (ds_q == DS_IDLE) && mem_ready && !issue_rd_s && (count_s != '0);
    assign done_s     = (ds_q == DS_BUSY) && mem_ready;
    assign pop_s      = done_s && !op_rd_q;
    assign count_nx_s = count_s + CW'(push_s) - CW'(pop_s);

`ifdef WRITE_BUFFER_COALESCE_EN
    logic                     co_hit_s, merge_s, head_busy_s;
    logic [$clog2(DEPTH)-1:0] co_idx_s;

    // Head counts as in flight from the cycle it is being issued
    assign head_busy_s = ((ds_q != DS_IDLE) && !op_rd_q) || issue_wr_s;
    assign merge_s     = wr_req_s && co_hit_s;
    assign push_s      = wr_req_s && !co_hit_s;
`else
    assign push_s      = wr_req_s;
`endif

    write_buffer_fifo #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .WORD_WIDTH (WORD_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push_s),
        .pop_i       (pop_s),
        .addr_i      (addr),
        .data_i      (din),
`ifdef WRITE_BUFFER_COALESCE_EN
        .head_busy_i (head_busy_s),
        .merge_i     (merge_s),
        .co_hit_o    (co_hit_s),
        .co_idx_o    (co_idx_s),
`endif
        .count_o     (count_s),
        .head_addr_o (head_addr_s),
        .head_data_o (head_data_s),
        .hit_o       (hit_s),
        .hit_data_o  (hit_data_s)
    );

    // Upstream request FSM: hit forwarding, miss tracking and ready generation
    always_comb begin
        state_d     = state_q;
        dout_d      = dout_q;
        rd_addr_d   = rd_addr_q;
        rd_issued_d = rd_issued_q;
        case (state_q)
            IDLE: begin
                if (rd_req_s && hit_s) begin
                    state_d = RD_HIT;
                    dout_d  = hit_data_s;
                end else if (rd_req_s) begin
                    state_d     = RD_MISS;
                    rd_addr_d   = addr;
                    rd_issued_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            RD_HIT: begin
                state_d = IDLE;
            end
            RD_MISS: begin
                if (done_s && op_rd_q) begin
                    state_d = IDLE;
                    dout_d  = mem_dout;
                end else if (issue_rd_s) begin
                    rd_issued_d = 1'b1;
                end else begin
                    state_d = RD_MISS;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        ready_d = (state_d == IDLE) && (count_nx_s < CW'(DEPTH));
    end

    // Downstream FSM: a pending miss read outranks draining the head entry
    always_comb begin
        ds_d       = ds_q;
        mem_re_d   = 1'b0;
        mem_we_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        op_rd_d    = op_rd_q;
        case (ds_q)
            DS_IDLE: begin
                if (issue_rd_s) begin
                    mem_re_d   = 1'b1;
                    mem_addr_d = rd_addr_q;
                    op_rd_d    = 1'b1;
                    ds_d       = DS_ISSUE_WAIT;
                end else if (issue_wr_s) begin
                    mem_we_d   = 1'b1;
                    mem_addr_d = head_addr_s;
                    mem_din_d  = head_data_s;
                    op_rd_d    = 1'b0;
                    ds_d       = DS_ISSUE_WAIT;
                end else begin
                    ds_d = DS_IDLE;
                end
            end
            DS_ISSUE_WAIT: begin
                ds_d = DS_BUSY;
            end
            DS_BUSY: begin
                if (mem_ready) begin
                    ds_d = DS_IDLE;
                end else begin
                    ds_d = DS_BUSY;
                end
            end
            default: begin
                ds_d = DS_IDLE;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            ds_q        <= DS_IDLE;
            ready_q     <= 1'b1;
            dout_q      <= '0;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
            rd_addr_q   <= '0;
            rd_issued_q <= 1'b0;
            op_rd_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            ds_q        <= ds_d;
            ready_q     <= ready_d;
            dout_q      <= dout_d;
            mem_re_q    <= mem_re_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_din_q   <= mem_din_d;
            rd_addr_q   <= rd_addr_d;
            rd_issued_q <= rd_issued_d;
            op_rd_q     <= op_rd_d;
        end
    end

    assign ready    = ready_q;
    assign dout     = dout_q;
    assign mem_re   = mem_re_q;
    assign mem_we   = mem_we_q;
    assign mem_addr = mem_addr_q;
    assign mem_din  = mem_din_q;

endmodule

// File: tb/tb_write_buffer.sv
// Directed and randomized checks of write_buffer against a transparent-memory reference model
// and a latency-programmable ram responder.
module tb_write_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] addr = '0;
    logic [63:0] din = '0;
    logic [63:0] dout;
    logic        re = 1'b0;
    logic        we = 1'b0;
    logic        ready;
    logic [63:0] mem_addr;
    logic [63:0] mem_din;
    logic [63:0] mem_dout = '0;
    logic        mem_re;
    logic        mem_we;
    logic        mem_ready = 1'b1;

    write_buffer #(.ADDR_WIDTH(64), .WORD_WIDTH(64), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .addr(addr), .din(din), .dout(dout), .re(re), .we(we),
        .ready(ready), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
        .mem_re(mem_re), .mem_we(mem_we), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: the buffer must be invisible, so reads see the latest write to each address
    logic [63:0] ref_mem [logic [63:0]];
    logic [63:0] exp_wa[$];
    logic [63:0] exp_wd[$];

    // Ram responder state and issue log
    logic [63:0] ram_mem [logic [63:0]];
    int          ram_lat = 4;
    int          ram_cnt = 0;
    bit          ram_busy = 1'b0;
    bit          ram_rd = 1'b0;
    logic [63:0] ram_a, ram_d;
    int          cyc = 0;
    int          last_commit_cyc = 0;
    bit          prev_strobe = 1'b0;
    bit          ev_rd[$];
    logic [63:0] ev_addr[$];
    logic [63:0] ev_data[$];

    function automatic logic [63:0] ram_default(input logic [63:0] a);
        return a ^ 64'h5a5a_0000_c3c3_0000;
    endfunction

    function automatic logic [63:0] ram_peek(input logic [63:0] a);
        return ram_mem.exists(a) ? ram_mem[a] : ram_default(a);
    endfunction

    function automatic logic [63:0] model_rd(input logic [63:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : ram_default(a);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Ram: samples strobes 2 time units after the clock edge, completes after ram_lat cycles
    always @(posedge clk) begin
        #2;
        cyc++;
        if (mem_re || mem_we) begin
            chk("strobe_exclusive", 64'(mem_re & mem_we), 64'd0);
            chk("strobe_single_cycle", 64'(prev_strobe), 64'd0);
        end
        prev_strobe = mem_re | mem_we;
        if (ram_busy) begin
            ram_cnt--;
            if (ram_cnt <= 0) begin
                ram_busy = 1'b0;
                mem_ready = 1'b1;
                last_commit_cyc = cyc;
                if (ram_rd) mem_dout = ram_peek(ram_a);
                else ram_mem[ram_a] = ram_d;
            end
        end else if ((mem_re || mem_we) && mem_ready) begin
            ram_busy = 1'b1;
            mem_ready = 1'b0;
            ram_cnt = ram_lat;
            ram_rd = mem_re;
            ram_a = mem_addr;
            ram_d = mem_din;
            ev_rd.push_back(mem_re);
            ev_addr.push_back(mem_addr);
            ev_data.push_back(mem_din);
        end
    end

    task automatic wait_ready(input string tag);
        int n = 0;
        while (ready !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (ready !== 1'b1) chk(tag, 64'(ready), 64'd1);
    endtask

    task automatic do_write(input logic [63:0] a, input logic [63:0] d);
        wait_ready("write_wait_timeout");
        addr = a; din = d; we = 1'b1;
        @(negedge clk);
        we = 1'b0;
        ref_mem[a] = d;
        exp_wa.push_back(a);
        exp_wd.push_back(d);
    endtask

    task automatic do_read(input logic [63:0] a, output logic [63:0] got, output int low);
        wait_ready("read_wait_timeout");
        addr = a; re = 1'b1;
        @(negedge clk);
        re = 1'b0;
        low = 0;
        while (ready !== 1'b1 && low < 3000) begin
            @(negedge clk);
            low++;
        end
        if (ready !== 1'b1) chk("read_done_timeout", 64'(ready), 64'd1);
        got = dout;
    endtask

    task automatic wait_drain();
        int idle = 0;
        int n = 0;
        while (idle < 6 && n < 5000) begin
            @(negedge clk);
            n++;
            if (!ram_busy && mem_ready && !mem_we && !mem_re) idle++;
            else idle = 0;
        end
        if (idle < 6) chk("drain_timeout", 64'(idle), 64'd6);
    endtask

    initial begin
        logic [63:0] got;
        logic [63:0] d [4];
        logic [63:0] w256[$];
        logic [63:0] a;
        int          low, base, n, p_rd, p_w, nw;

        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 64'(ready), 64'd1);
        chk("rst_dout", dout, 64'd0);
        chk("rst_mem_re", 64'(mem_re), 64'd0);
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        chk("rst_mem_addr", mem_addr, 64'd0);
        chk("rst_mem_din", mem_din, 64'd0);
        rst = 1'b1;
        @(negedge clk);

        // Single write, slow ram
        ram_lat = 100;
        base = ev_addr.size();
        do_write(64'd1, 64'h0123456789abcdef);
        chk("t1_ready_after_write", 64'(ready), 64'd1);
        n = 0;
        while (ev_addr.size() == base && n < 3) begin
            @(negedge clk);
            n++;
        end
        chk("t1_mem_we_count", 64'(ev_addr.size() - base), 64'd1);
        chk("t1_mem_addr", (ev_addr.size() > base) ? ev_addr[base] : 64'hffff, 64'd1);
        wait_drain();
        chk("t1_ram_data", ram_peek(64'd1), 64'h0123456789abcdef);

        // Forwarding hit before ram completes
        ram_lat = 20;
        do_write(64'd257, 64'd123);
        do_read(64'd257, got, low);
        chk("t2_hit_data", got, 64'd123);
        chk("t2_hit_ready_low", 64'(low), 64'd1);
        chk("t2_before_ram", 64'(ram_mem.exists(64'd257)), 64'd0);
        wait_drain();

        // Fill to DEPTH while ram is busy
        for (int i = 0; i < 4; i++) d[i] = {$urandom, $urandom};
        for (int i = 0; i < 4; i++) do_write(64'd10 + 64'(i), d[i]);
        chk("t3_full_not_ready", 64'(ready), 64'd0);
        n = 0;
        while (ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("t3_ready_back", 64'(ready), 64'd1);
        chk("t3_ready_cycle", 64'(cyc), 64'(last_commit_cyc + 1));
        wait_drain();
        for (int i = 0; i < 4; i++) chk("t3_ram_data", ram_peek(64'd10 + 64'(i)), d[i]);

        // Miss read bypasses the second queued write
        ram_mem[64'd500] = 64'd77;
        ref_mem[64'd500] = 64'd77;
        base = ev_addr.size();
        do_write(64'd600, {$urandom, $urandom});
        do_write(64'd601, {$urandom, $urandom});
        do_read(64'd500, got, low);
        chk("t4_miss_data", got, 64'd77);
        wait_drain();
        p_rd = -1;
        p_w = -1;
        for (int i = base; i < ev_addr.size(); i++) begin
            if (ev_rd[i] && ev_addr[i] == 64'd500 && p_rd < 0) p_rd = i;
            if (!ev_rd[i] && ev_addr[i] == 64'd601 && p_w < 0) p_w = i;
        end
        chk("t4_read_before_write", 64'((p_rd >= 0) && (p_w > p_rd)), 64'd1);

        // Duplicate address writes behind a busy ram
        base = ev_addr.size();
        do_write(64'd300, 64'd55);
        do_write(64'd256, 64'd321);
        do_write(64'd256, 64'd999);
        do_read(64'd256, got, low);
        chk("t5_newest_data", got, 64'd999);
        chk("t5_hit_ready_low", 64'(low), 64'd1);
        wait_drain();
        for (int i = base; i < ev_addr.size(); i++)
            if (!ev_rd[i] && ev_addr[i] == 64'd256) w256.push_back(ev_data[i]);
`ifdef WRITE_BUFFER_COALESCE_EN
        chk("t5_mem_we_count", 64'(w256.size()), 64'd1);
        chk("t5_merged_data", (w256.size() > 0) ? w256[0] : 64'hffff, 64'd999);
`else
        chk("t5_mem_we_count", 64'(w256.size()), 64'd2);
        chk("t5_first_data", (w256.size() > 0) ? w256[0] : 64'hffff, 64'd321);
        chk("t5_second_data", (w256.size() > 1) ? w256[1] : 64'hffff, 64'd999);
`endif
        chk("t5_ram_data", ram_peek(64'd256), 64'd999);

        // Random mix over a small address window
        for (int i = 0; i < 60; i++) begin
            ram_lat = $urandom_range(1, 8);
            a = 64'h1000 + 64'($urandom_range(0, 5));
            if ($urandom_range(0, 1) == 0) begin
                do_write(a, {$urandom, $urandom});
            end else begin
                do_read(a, got, low);
                chk("rand_read", got, model_rd(a));
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        wait_drain();
        foreach (ref_mem[k]) chk("final_ram", ram_peek(k), ref_mem[k]);
`ifndef WRITE_BUFFER_COALESCE_EN
        nw = 0;
        for (int i = 0; i < ev_addr.size(); i++) begin
            if (!ev_rd[i]) begin
                if (nw < exp_wa.size()) begin
                    chk("order_addr", ev_addr[i], exp_wa[nw]);
                    chk("order_data", ev_data[i], exp_wd[nw]);
                end
                nw++;
            end
        end
        chk("order_count", 64'(nw), 64'(exp_wa.size()));
`endif

        // Reset while a write is in flight with more queued
        ram_lat = 30;
        do_write(64'd700, 64'd7);
        do_write(64'd701, 64'd8);
        do_write(64'd702, 64'd9);
        repeat (3) @(negedge clk);
        chk("t6_in_flight", 64'(ram_busy), 64'd1);
        rst = 1'b0;
        #1;
        chk("t6_ready", 64'(ready), 64'd1);
        chk("t6_dout", dout, 64'd0);
        chk("t6_mem_re", 64'(mem_re), 64'd0);
        chk("t6_mem_we", 64'(mem_we), 64'd0);
        chk("t6_mem_addr", mem_addr, 64'd0);
        chk("t6_mem_din", mem_din, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        base = ev_addr.size();
        repeat (80) @(negedge clk);
        chk("t6_no_more_issue", 64'(ev_addr.size() - base), 64'd0);
        chk("t6_ready_after", 64'(ready), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
